// File: rtl/aes_encipher_block_if.sv
// Bus between the core control / key memory and the iterative AES encipher datapath.
// The master side issues requests and supplies round keys; the slave side is the datapath.
interface aes_encipher_block_if;
    logic         next;
    logic         keylen;
    logic [127:0] block;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic [127:0] new_block;
    logic         ready;

    modport master (
        output next,
        output keylen,
        output block,
        output round_key,
        input  round,
        input  new_block,
        input  ready
    );

    modport slave (
        input  next,
        input  keylen,
        input  block,
        input  round_key,
        output round,
        output new_block,
        output ready
    );
endinterface

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/AES-256 encipher datapath, one cipher round per clock.
// Round keys are fetched from an external key memory addressed by the round output.

module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so entry x starts at bit 8*(255-x) = {~x, 3'b000}.
    assign sub_val = SBOX_TABLE[{~byte_val, 3'b000} +: 8];
endmodule

module aes_encipher_block #(
    parameter int AES128_ROUNDS = 10,
    parameter int AES256_ROUNDS = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    aes_encipher_block_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, INIT, MAIN, FINAL} fsm_t;

    fsm_t         fsm_state;
    fsm_t         fsm_next;
    logic [127:0] state_reg;
    logic [127:0] state_new;
    logic [127:0] new_block_reg;
    logic [127:0] new_block_new;
    logic [3:0]   round_reg;
    logic [3:0]   round_new;
    logic [3:0]   nr_reg;
    logic [3:0]   nr_new;
    logic         ready_reg;
    logic         ready_new;
    logic [127:0] sub_bytes_out;
    logic [127:0] shifted;
    logic [127:0] mixed;

    function automatic logic [7:0] gmul2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return gmul2(x) ^ x;
    endfunction

    // Row r of column c moves in from column (c + r) mod 4; bytes are column-major.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int col = 0; col < 4; col++) begin
            for (int row = 0; row < 4; row++) begin
                o[127 - 8 * (4 * col + row) -: 8] = s[127 - 8 * (4 * ((col + row) % 4) + row) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a, b, c, d;
        o = '0;
        for (int col = 0; col < 4; col++) begin
            a = s[127 - 32 * col -: 8];
            b = s[119 - 32 * col -: 8];
            c = s[111 - 32 * col -: 8];
            d = s[103 - 32 * col -: 8];
            o[127 - 32 * col -: 32] = {gmul2(a) ^ gmul3(b) ^ c ^ d,
                                       a ^ gmul2(b) ^ gmul3(c) ^ d,
                                       a ^ b ^ gmul2(c) ^ gmul3(d),
                                       gmul3(a) ^ b ^ c ^ gmul2(d)};
        end
        return o;
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_val (state_reg[127 - 8 * i -: 8]),
            .sub_val  (sub_bytes_out[127 - 8 * i -: 8])
        );
    end

    assign shifted = shift_rows(sub_bytes_out);
    assign mixed   = mix_columns(shifted);

    // Round sequencing: INIT whitens with key 0, MAIN runs full rounds 1..Nr-1,
    // FINAL skips MixColumns and is the only place the visible result changes.
    always_comb begin
        fsm_next      = fsm_state;
        state_new     = state_reg;
        new_block_new = new_block_reg;
        round_new     = round_reg;
        nr_new        = nr_reg;
        ready_new     = ready_reg;
        case (fsm_state)
            IDLE: begin
                round_new = 4'd0;
                ready_new = 1'b1;
                if (bus.next) begin
                    state_new = bus.block;
                    nr_new    = bus.keylen ? 4'(AES256_ROUNDS) : 4'(AES128_ROUNDS);
                    ready_new = 1'b0;
                    fsm_next  = INIT;
                end
            end
            INIT: begin
                state_new = state_reg ^ bus.round_key;
                round_new = 4'd1;
                fsm_next  = MAIN;
            end
            MAIN: begin
                state_new = mixed ^ bus.round_key;
                round_new = round_reg + 4'd1;
                if (round_reg == nr_reg - 4'd1) begin
                    fsm_next = FINAL;
                end
            end
            FINAL: begin
                new_block_new = shifted ^ bus.round_key;
                ready_new     = 1'b1;
                round_new     = 4'd0;
                fsm_next      = IDLE;
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // Reset discards any operation in flight, including its partial result.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_state     <= IDLE;
            state_reg     <= '0;
            new_block_reg <= '0;
            round_reg     <= 4'd0;
            nr_reg        <= 4'(AES128_ROUNDS);
            ready_reg     <= 1'b1;
        end else begin
            fsm_state     <= fsm_next;
            state_reg     <= state_new;
            new_block_reg <= new_block_new;
            round_reg     <= round_new;
            nr_reg        <= nr_new;
            ready_reg     <= ready_new;
        end
    end

    assign bus.round     = round_reg;
    assign bus.new_block = new_block_reg;
    assign bus.ready     = ready_reg;
endmodule

// File: tb/tb_aes_encipher_block.sv
// Directed FIPS-197 vectors against the encipher datapath, with a bench-side key schedule
// standing in for the key memory, plus abort, ignore and back-to-back sequences.
module tb_aes_encipher_block;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct {
        string        name;
        logic [255:0] key;
        logic         klen;
        logic [127:0] pt;
        logic [127:0] ct;
        int           lat;
    } vec_t;

    logic         clk;
    logic         reset;
    logic [127:0] rk [0:15];
    logic [127:0] exp_nb;
    int           total;
    int           bad;
    int           busy;
    vec_t         vecs [3];

    aes_encipher_block_if bus ();

    aes_encipher_block dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.round_key = rk[bus.round];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX;
        return t[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    // Fills the round-key table the way the key memory would present it.
    task automatic expandKey(input logic [255:0] key, input logic klen);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nk;
        int          nwords;
        nk     = klen ? 8 : 4;
        nwords = klen ? 60 : 44;
        rcon   = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < nwords; i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}});
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            rk[r] = (4 * r + 3 < nwords) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] pt, input logic klen, input logic [255:0] key,
                                 input bit hold);
        expandKey(key, klen);
        bus.block  = pt;
        bus.keylen = klen;
        bus.next   = 1'b1;
        step();
        if (!hold) bus.next = 1'b0;
        checkOutput("accept_ready", 128'(bus.ready), 128'd0);
    endtask

    // Walks the busy window from the first post-start sample; optionally pokes inputs or aborts.
    task automatic waitDone(input int poke_at, input int reset_at, output int cycles);
        cycles = 0;
        while (bus.ready === 1'b0 && cycles < 64) begin
            checkOutput("round_seq", 128'(bus.round), 128'(cycles));
            checkOutput("hold_new_block", bus.new_block, exp_nb);
            if (cycles == reset_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                exp_nb = '0;
                checkOutput("abort_ready", 128'(bus.ready), 128'd1);
                checkOutput("abort_round", 128'(bus.round), 128'd0);
                checkOutput("abort_new_block", bus.new_block, 128'd0);
                return;
            end
            if (poke_at >= 0 && cycles == poke_at) begin
                bus.next   = 1'b1;
                bus.block  = ~bus.block;
                bus.keylen = ~bus.keylen;
            end else if (poke_at >= 0 && cycles == poke_at + 1) begin
                bus.next = 1'b0;
            end
            step();
            cycles++;
        end
        if (cycles >= 64) checkOutput("timeout", 128'(cycles), 128'd0);
    endtask

    task automatic finishCheck(input logic [127:0] ct, input int lat, input int cycles);
        checkOutput("ready_back", 128'(bus.ready), 128'd1);
        checkOutput("latency", 128'(cycles), 128'(lat));
        checkOutput("ciphertext", bus.new_block, ct);
        checkOutput("round_idle", 128'(bus.round), 128'd0);
        exp_nb = ct;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_nb = '0;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        vecs[0] = '{"fips_b", {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0,
                    128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 11};
        vecs[1] = '{"fips_c1", {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0,
                    128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 11};
        vecs[2] = '{"fips_c3", 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1,
                    128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 15};

        reset      = 1'b1;
        bus.next   = 1'b0;
        bus.keylen = 1'b0;
        bus.block  = '0;
        step();
        step();
        checkOutput("reset_ready", 128'(bus.ready), 128'd1);
        checkOutput("reset_round", 128'(bus.round), 128'd0);
        checkOutput("reset_new_block", bus.new_block, 128'd0);
        reset = 1'b0;
        step();

        for (int v = 0; v < 3; v++) begin
            $display("[TB] vector %s", vecs[v].name);
            applyStimulus(vecs[v].pt, vecs[v].klen, vecs[v].key, 1'b0);
            waitDone(-1, -1, busy);
            finishCheck(vecs[v].ct, vecs[v].lat, busy);
            step();
        end

        $display("[TB] next pulsed while busy");
        applyStimulus(vecs[1].pt, 1'b0, vecs[1].key, 1'b0);
        waitDone(5, -1, busy);
        finishCheck(vecs[1].ct, 11, busy);
        step();

        $display("[TB] reset mid-operation");
        applyStimulus(vecs[0].pt, 1'b0, vecs[0].key, 1'b0);
        waitDone(-1, 6, busy);
        step();
        applyStimulus(vecs[1].pt, 1'b0, vecs[1].key, 1'b0);
        waitDone(-1, -1, busy);
        finishCheck(vecs[1].ct, 11, busy);
        step();

        $display("[TB] back-to-back with next held");
        applyStimulus(vecs[1].pt, 1'b0, vecs[1].key, 1'b1);
        waitDone(-1, -1, busy);
        finishCheck(vecs[1].ct, 11, busy);
        bus.block = vecs[0].pt;
        expandKey(vecs[0].key, 1'b0);
        step();
        checkOutput("b2b_accept", 128'(bus.ready), 128'd0);
        bus.next = 1'b0;
        waitDone(-1, -1, busy);
        finishCheck(vecs[0].ct, 11, busy);
        step();

        $display("[TB] reset together with next");
        reset    = 1'b1;
        bus.next = 1'b1;
        step();
        reset    = 1'b0;
        bus.next = 1'b0;
        checkOutput("rst_next_ready", 128'(bus.ready), 128'd1);
        checkOutput("rst_next_new_block", bus.new_block, 128'd0);
        step();
        checkOutput("rst_next_stays_idle", 128'(bus.ready), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
